// File: rtl/switch_reader_pkg.sv
// switch_reader_pkg: shared state type and default parameters for the switch reader.
package switch_reader_pkg;
  typedef enum logic {ACQUIRE, TRACK} state_e;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CYCLES = 4;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-bit flop synchroniser for asynchronous pin inputs.
module sync_chain #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;
  always_comb stage_d = {stage_q[STAGES-2:0], d};
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else stage_q <= stage_d;
  end
  assign q = stage_q[STAGES-1];
endmodule

// File: rtl/switch_reader.sv
// switch_reader: synchronises and debounces the slide-switch bank into a clean code with a change strobe.
module switch_reader
  import switch_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch,
  output logic             valid,
  output logic             changed
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
  logic [WIDTH-1:0] s, cand_q, cand_d, switch_q, switch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, changed_q, changed_d, commit;
  state_e state_q, state_d;
  sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .d(switch_raw), .q(s)
  );
  // Commit is decided on the edge the counter reaches full, so it lands together with the last count.
  always_comb begin
    cand_d = enable ? s : cand_q;
    cnt_d = !enable ? cnt_q : (s != cand_q) ? CW'(1) : (cnt_q < FULL) ? cnt_q + 1'b1 : cnt_q;
    commit = enable && (cnt_d == FULL) && (state_q == ACQUIRE || cand_d != switch_q);
  end
  always_comb state_d = commit ? TRACK : state_q;
  always_comb begin
    switch_d = commit ? cand_d : switch_q;
    valid_d = valid_q | commit;
    changed_d = commit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q <= '0;
      state_q <= ACQUIRE;
      switch_q <= '0;
      valid_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      switch_q <= switch_d;
      valid_q <= valid_d;
      changed_q <= changed_d;
    end
  end
  assign switch = switch_q;
  assign valid = valid_q;
  assign changed = changed_q;
endmodule

// File: tb/tb_switch_reader.sv
// tb_switch_reader: directed self-checking bench for switch_reader with default parameters.
module tb_switch_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic [2:0] switch_raw = 3'd0;
  logic [2:0] switch;
  logic valid, changed;
  int total = 0;
  int passed = 0;

  switch_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .switch_raw(switch_raw),
    .switch(switch), .valid(valid), .changed(changed)
  );

  always #5 clk = ~clk;

  // Apply inputs just after an edge, advance one edge, then sample 1 time unit later.
  task automatic cyc(input logic [2:0] raw, input logic en, input logic r);
    switch_raw = raw;
    enable = en;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) cyc(3'd5, 1'b1, 1'b1);
    total++;
    if ({switch, valid, changed} !== 5'b0) $display("FAIL reset_state got sw=%0d v=%0b c=%0b want 0/0/0", switch, valid, changed);
    else passed++;
  endtask

  task automatic test_acquire;
    for (int i = 1; i <= 7; i++) begin
      logic [2:0] esw;
      logic ev, ec;
      cyc(3'd5, 1'b1, 1'b0);
      esw = (i >= 6) ? 3'd5 : 3'd0;
      ev = (i >= 6);
      ec = (i == 6);
      total++;
      if (switch !== esw || valid !== ev || changed !== ec)
        $display("FAIL acquire edge%0d got sw=%0d v=%0b c=%0b want sw=%0d v=%0b c=%0b", i, switch, valid, changed, esw, ev, ec);
      else passed++;
    end
  endtask

  task automatic test_bounce;
    int pulses = 0;
    for (int i = 0; i <= 13; i++) begin
      logic [2:0] raw, esw;
      logic ec;
      raw = (i < 6 && i[0]) ? 3'd5 : 3'd2;
      cyc(raw, 1'b1, 1'b0);
      if (changed === 1'b1) pulses++;
      esw = (i >= 11) ? 3'd2 : 3'd5;
      ec = (i == 11);
      total++;
      if (switch !== esw || changed !== ec)
        $display("FAIL bounce edge%0d got sw=%0d c=%0b want sw=%0d c=%0b", i, switch, changed, esw, ec);
      else passed++;
    end
    total++;
    if (pulses !== 1) $display("FAIL bounce_pulses got %0d want 1", pulses);
    else passed++;
  endtask

  task automatic test_glitch;
    int pulses = 0;
    int bad = 0;
    for (int i = 0; i < 12; i++) begin
      cyc((i < 2) ? 3'd7 : 3'd2, 1'b1, 1'b0);
      if (changed !== 1'b0) pulses++;
      if (switch !== 3'd2) bad++;
    end
    total++;
    if (pulses !== 0 || bad !== 0) $display("FAIL glitch got pulses=%0d bad_sw=%0d want 0/0", pulses, bad);
    else passed++;
  endtask

  task automatic test_enable_hold;
    for (int i = 0; i <= 16; i++) begin
      logic [2:0] esw;
      logic ec;
      cyc(3'd6, !(i >= 3 && i <= 12), 1'b0);
      esw = (i >= 15) ? 3'd6 : 3'd2;
      ec = (i == 15);
      total++;
      if (switch !== esw || changed !== ec || valid !== 1'b1)
        $display("FAIL enable_hold edge%0d got sw=%0d v=%0b c=%0b want sw=%0d v=1 c=%0b", i, switch, valid, changed, esw, ec);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 10; i++) cyc(3'd4, 1'b1, 1'b0);
    total++;
    if (switch !== 3'd4) $display("FAIL settle4 got sw=%0d want 4", switch);
    else passed++;
    cyc(3'd1, 1'b1, 1'b0);
    cyc(3'd1, 1'b1, 1'b0);
    cyc(3'd1, 1'b1, 1'b0);
    cyc(3'd1, 1'b1, 1'b1);
    total++;
    if ({switch, valid, changed} !== 5'b0) $display("FAIL mid_reset got sw=%0d v=%0b c=%0b want 0/0/0", switch, valid, changed);
    else passed++;
    for (int i = 1; i <= 7; i++) begin
      logic [2:0] esw;
      logic ev, ec;
      cyc(3'd1, 1'b1, 1'b0);
      esw = (i >= 6) ? 3'd1 : 3'd0;
      ev = (i >= 6);
      ec = (i == 6);
      total++;
      if (switch !== esw || valid !== ev || changed !== ec)
        $display("FAIL reacquire edge%0d got sw=%0d v=%0b c=%0b want sw=%0d v=%0b c=%0b", i, switch, valid, changed, esw, ev, ec);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_acquire;
    test_bounce;
    test_glitch;
    test_enable_hold;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
